// File: rtl/lane_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_pkg
// Description : Shared definitions for the lane serializer slice: the idle
//               symbol values, the serializer state encoding and a small
//               width helper for counters and pointers.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_pkg;

    // Comma symbol sent as the idle/sync pattern when IDLE_COM_EN is defined.
    localparam logic [7:0] COM_SYMBOL = 8'hBC;
    // Idle pattern when the comma/sync feature is disabled.
    localparam logic [7:0] IDLE_ZERO  = 8'h00;

    typedef enum logic [0:0] {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } lane_state_t;

    // Bits needed to index n items; never returns zero so that degenerate
    // parameter values still yield a legal vector width.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : lane_pkg
`default_nettype wire

// File: rtl/lane_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lane_fifo
// Description : Synchronous FIFO buffering bytes ahead of the serializer.
//               Count, full and empty come from registered state only, so a
//               push is refused while full even if a pop happens on the same
//               edge (no pass-through path).
// Ports       : clk, reset_L      - clock, asynchronous active-low reset
//               i_push/i_push_data - write request and byte
//               i_pop              - read request (ignored when empty)
//               o_pop_data         - byte at the head of the buffer
//               o_full/o_empty     - occupancy flags
//               o_count            - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module lane_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);
    import lane_pkg::*;

    localparam int              PTR_W   = cnt_width(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full     = (r_count == c_DEPTH);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop  && !o_empty;

    // Storage needs no reset: entries are only read once the count says so.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : lane_fifo
`default_nettype wire

// File: rtl/lane_serializer.sv
`default_nettype none
// ============================================================================
// Module      : lane_serializer
// Description : Buffers bytes from one demux lane and shifts them out MSB
//               first, one bit per clock. Symbol boundaries occur every
//               DATA_W cycles; at each boundary the shift register loads
//               either the buffer head (valid_out=1) or the idle symbol.
//               Optional macro IDLE_COM_EN: idle symbol is the COM character
//               and SYNC_COUNT idle symbols are forced after reset before any
//               data may leave. Without it the idle symbol is 0x00 and the
//               serializer starts directly in ACTIVE.
// Ports       : clk        - bit-rate clock
//               reset_L    - asynchronous active-low reset
//               data_in    - byte from the lane
//               valid_in   - data_in holds a byte
//               ready_out  - buffer can accept a byte this cycle
//               data_out   - serial bit, MSB first
//               frame_out  - high on the first bit of every symbol
//               valid_out  - high for every bit of a data symbol
//               fifo_count - buffer occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module lane_serializer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SYNC_COUNT = 4
) (
    input  logic                                clk,
    input  logic                                reset_L,
    input  logic [DATA_W-1:0]                   data_in,
    input  logic                                valid_in,
    output logic                                ready_out,
    output logic                                data_out,
    output logic                                frame_out,
    output logic                                valid_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);
    import lane_pkg::*;

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W  = cnt_width(DATA_W);
    localparam int SYNC_W = cnt_width(SYNC_COUNT);

    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(DATA_W - 1);

`ifdef IDLE_COM_EN
    localparam logic [DATA_W-1:0] c_IDLE_SYM    = DATA_W'(COM_SYMBOL);
    localparam lane_state_t       c_RESET_STATE = SYNC;
`else
    localparam logic [DATA_W-1:0] c_IDLE_SYM    = DATA_W'(IDLE_ZERO);
    localparam lane_state_t       c_RESET_STATE = ACTIVE;
`endif

    lane_state_t       r_state;
    lane_state_t       w_state_nxt;
    logic [SYNC_W-1:0] r_sync_cnt;
    logic [SYNC_W-1:0] w_sync_nxt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_valid;

    logic              w_boundary;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_load_sym;

    // ------------------------------------------------------------------
    // Input buffer
    // ------------------------------------------------------------------
    assign ready_out = !w_full;
    assign w_push    = valid_in && ready_out;

    lane_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .reset_L     (reset_L),
        .i_push      (w_push),
        .i_push_data (data_in),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Symbol sequencing
    // ------------------------------------------------------------------
    assign w_boundary = (r_bit_cnt == c_LAST_BIT);

    // The symbol already on the wire at reset release counts as the first
    // sync symbol, so r_sync_cnt + 1 is the number completed at a boundary.
    // The boundary that completes the last sync symbol already behaves as
    // ACTIVE, letting a waiting byte go out immediately afterwards.
    always_comb begin
        w_state_nxt = r_state;
        w_sync_nxt  = r_sync_cnt;
        w_pop       = 1'b0;
        if (w_boundary) begin
            case (r_state)
                SYNC: begin
                    if ((int'(r_sync_cnt) + 1) >= SYNC_COUNT) begin
                        w_state_nxt = ACTIVE;
                        w_pop       = !w_empty;
                    end else begin
                        w_sync_nxt  = r_sync_cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    w_pop = !w_empty;
                end
                default: begin
                    w_state_nxt = c_RESET_STATE;
                end
            endcase
        end
    end

    assign w_load_sym = w_pop ? w_head : c_IDLE_SYM;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= c_RESET_STATE;
            r_sync_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_cnt <= w_sync_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_bit_cnt <= '0;
            r_shreg   <= c_IDLE_SYM;
            r_valid   <= 1'b0;
        end else if (w_boundary) begin
            r_bit_cnt <= '0;
            r_shreg   <= w_load_sym;
            r_valid   <= w_pop;
        end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
        end
    end

    assign data_out  = r_shreg[DATA_W-1];
    assign frame_out = (r_bit_cnt == '0);
    assign valid_out = r_valid;

endmodule : lane_serializer
`default_nettype wire

// File: doc/lane_serializer.md
LANE_SERIALIZER -- requirements
Module: lane_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning symbol width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning input buffer entries (power of two, >=2).
REQ-003 SHALL have parameter SYNC_COUNT, default 4, meaning idle symbols sent after reset before data is allowed.
REQ-004 SHALL have port clk  input  1  single bit-rate clock; all logic on rising edge.
REQ-005 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data_in  input  DATA_W  byte from one demux lane output.
REQ-007 SHALL have port valid_in  input  1  data_in holds a valid byte.
REQ-008 SHALL have port ready_out  output  1  buffer can accept a byte this cycle.
REQ-009 SHALL have port data_out  output  1  serial bit, MSB first.
REQ-010 SHALL have port frame_out  output  1  high while data_out carries bit DATA_W-1 (first bit) of a symbol.
REQ-011 SHALL have port valid_out  output  1  high for every bit of a data symbol, low for idle symbols.
REQ-012 SHALL have port fifo_count  output  clog2(FIFO_DEPTH+1)  current buffer occupancy.

Function
REQ-013 Push: a byte SHALL be written when valid_in && ready_out at a rising edge; ready_out = (fifo_count < FIFO_DEPTH), derived from registered state only.
REQ-014 Push while full SHALL NOT occur even if a pop happens in the same cycle (no pass-through); the held byte is not lost, and the upstream stage holds it.
REQ-015 Bit counter bit_cnt SHALL count 0..DATA_W-1 and wrap; at an edge with bit_cnt==DATA_W-1 the shift register SHALL load the next symbol, otherwise it SHALL shift left by one.
REQ-016 data_out SHALL equal shift register MSB; frame_out SHALL equal (bit_cnt==0); valid_out SHALL be a registered flag loaded with each symbol.
REQ-017 State machine SHALL have states SYNC and ACTIVE; SYNC counts loaded idle symbols and transitions to ACTIVE at the boundary load where SYNC_COUNT idle symbols have completed; ACTIVE is terminal until reset.
REQ-018 In SYNC the load SHALL select the idle symbol regardless of buffer contents; pushes SHALL still be accepted.
REQ-019 In ACTIVE the load SHALL pop the buffer head if fifo_count>0 (valid_out=1), else load the idle symbol (valid_out=0, no pop).
REQ-020 A push and a pop at the same edge SHALL leave fifo_count unchanged; a byte pushed into an empty buffer at a boundary edge SHALL wait for the next boundary (no bypass).
REQ-021 Bytes SHALL be serialized in push order; minimum latency in ACTIVE is from push to the first bit at the next boundary, at most DATA_W+1 cycles.

Reset
REQ-022 While reset_L low: bit_cnt=0, shift register=idle symbol, valid_out=0, fifo_count=0, buffer pointers=0, sync counter=0, state=SYNC (ACTIVE without the macro).
REQ-023 Therefore during reset data_out=idle MSB, frame_out=1, ready_out=1; the symbol present at reset release SHALL count as the first sync symbol.
REQ-024 Reset asserted mid-symbol SHALL truncate the symbol immediately and discard all buffered bytes.

Configuration
REQ-025 With IDLE_COM_EN defined: idle symbol SHALL be COM 8'hBC and the SYNC phase of SYNC_COUNT symbols SHALL be present.
REQ-026 Without IDLE_COM_EN: idle symbol SHALL be 8'h00, SYNC SHALL be omitted (reset to ACTIVE), and SYNC_COUNT SHALL be ignored.

Structure
REQ-027 Shared package lane_pkg SHALL hold COM_SYMBOL (8'hBC), IDLE_ZERO (8'h00), and the state encoding (SYNC, ACTIVE).
REQ-028 Buffer SHALL be a sub-module lane_fifo (synchronous FIFO, registered count, push/pop/full/empty); serializer, counter and FSM stay in lane_serializer.

Verification
REQ-029 IDLE_COM_EN, reset release, valid_in=0 for 64 cycles -> data_out repeats 1,0,1,1,1,1,0,0; frame_out every 8th cycle; valid_out=0 throughout.
REQ-030 IDLE_COM_EN, push 8'hA5 at cycle 2 after reset -> byte held through 4 COM symbols; bits 1,0,1,0,0,1,0,1 start at cycle 32 with valid_out=1.
REQ-031 ACTIVE, back-to-back pushes 8'h01..8'h06 -> ready_out low at fifo_count=4; all six bytes emerge in order with no idle gap between them.
REQ-032 ACTIVE, buffer full, valid_in held with 8'h77 -> ready_out stays low until the next boundary pop; 8'h77 is accepted in the cycle after the pop, and is neither lost nor duplicated.
REQ-033 reset_L pulsed low at bit 3 of a data symbol with 3 bytes buffered -> fifo_count=0, frame_out=1, and only idle symbols are sent after release.
REQ-034 Built without IDLE_COM_EN, push 8'hFF right after reset -> first boundary emits 8'hFF; idle slots emit 0x00 with valid_out=0.
